// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing and types for the decode-stage register scoreboard.
// Counter width must hold MAX_INFLIGHT, so 2**CW-1 >= MAX_INFLIGHT.
package reg_sched_pkg;
    localparam int N_REGS       = 8;
    localparam int AW           = 3;
    localparam int MAX_INFLIGHT = 3;
    localparam int CW           = 2;
    localparam int SCW          = 16;

    typedef logic [CW-1:0]  cnt_t;
    typedef logic [AW-1:0]  reg_addr_t;
    typedef logic [SCW-1:0] stall_cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(MAX_INFLIGHT);
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback bundle between decode control and the scoreboard.
// Decode holds the issue fields stable while stall is high.
interface reg_sched_if;
    import reg_sched_pkg::*;

    logic              flush;
    logic              issue_valid;
    logic              src1_en;
    reg_addr_t         src1_addr;
    logic              src2_en;
    reg_addr_t         src2_addr;
    logic              dst_en;
    reg_addr_t         dst_addr;
    logic              wb_en;
    reg_addr_t         wb_addr;
    logic              stall;
    logic [N_REGS-1:0] busy;
    stall_cnt_t        stall_cnt;
    logic              underflow_err;

    modport master (
        output flush, issue_valid, src1_en, src1_addr, src2_en, src2_addr,
               dst_en, dst_addr, wb_en, wb_addr,
        input  stall, busy, stall_cnt, underflow_err
    );

    modport slave (
        input  flush, issue_valid, src1_en, src1_addr, src2_en, src2_addr,
               dst_en, dst_addr, wb_en, wb_addr,
        output stall, busy, stall_cnt, underflow_err
    );
endinterface

// File: rtl/reg_scoreboard_counter.sv
// In-flight write counter for one register; updates one cycle after inc/dec/clr.
// underflow_o pulses combinationally when a lone retire finds the count at zero.
module sb_counter
    import reg_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output cnt_t cnt_o,
    output logic underflow_o
);
    cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (dec_i && !inc_i) begin
            // A retire with nothing outstanding is held at zero and reported.
            if (cnt_q != '0) cnt_d = cnt_q - cnt_t'(1);
            else             underflow_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: combinational stall (0 cycles), counts/busy one cycle after edge.
// Stall holds decode; nothing is recorded for a stalled or flushed cycle.
module reg_scoreboard
    import reg_sched_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    reg_sched_if.slave bus
);
    cnt_t              cnt [N_REGS];
    logic [N_REGS-1:0] inc, wb_hit, uf_pulse, eff_busy, full_blk;
    logic              stall, acc;
    stall_cnt_t        stall_cnt_q, stall_cnt_d;
    logic              uf_q, uf_d;

    // A final same-cycle writeback frees the register: RF writes on rise, reads on fall.
    always_comb begin
        for (int i = 0; i < N_REGS; i++) begin
            eff_busy[i] = (cnt[i] != '0) && !(wb_hit[i] && cnt[i] == cnt_t'(1));
            full_blk[i] = (cnt[i] == CNT_FULL) && !wb_hit[i];
        end
    end

    assign stall = bus.issue_valid && !bus.flush &&
                   ((bus.src1_en && eff_busy[bus.src1_addr]) ||
                    (bus.src2_en && eff_busy[bus.src2_addr]) ||
                    (bus.dst_en  && full_blk[bus.dst_addr]));

    assign acc = bus.issue_valid && !stall && !bus.flush && bus.dst_en;

    for (genvar g = 0; g < N_REGS; g++) begin : g_reg
        assign wb_hit[g] = bus.wb_en && (bus.wb_addr == reg_addr_t'(g));
        assign inc[g]    = acc && (bus.dst_addr == reg_addr_t'(g));

        sb_counter u_cnt (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (bus.flush),
            .inc_i       (inc[g]),
            .dec_i       (wb_hit[g]),
            .cnt_o       (cnt[g]),
            .underflow_o (uf_pulse[g])
        );

        assign bus.busy[g] = (cnt[g] != '0);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + stall_cnt_t'(1);
        uf_d = uf_q | (|uf_pulse);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            uf_q        <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            uf_q        <= uf_d;
        end
    end

    assign bus.stall         = stall;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.underflow_err = uf_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed table, random run against a count model,
// stall-counter saturation and reset asserted mid-stall.
module tb_reg_scoreboard;
    import reg_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_sched_if bus();

    reg_scoreboard u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit iv; bit s1e; int s1; bit s2e; int s2; bit de; int d;
        bit we; int w; bit fl;
        bit exp_stall; int exp_busy;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: outstanding writes per register, stall cycles, sticky error.
    int m_cnt [N_REGS];
    int m_scnt;
    bit m_uf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit iv, bit s1e, int s1, bit s2e, int s2, bit de, int d,
                                bit we, int w, bit fl, bit es, int eb);
        vec_t v;
        v.iv = iv; v.s1e = s1e; v.s1 = s1; v.s2e = s2e; v.s2 = s2;
        v.de = de; v.d = d; v.we = we; v.w = w; v.fl = fl;
        v.exp_stall = es; v.exp_busy = eb;
        return v;
    endfunction

    function automatic bit m_hazard(int r, vec_t v);
        return m_cnt[r] != 0 && !(v.we && v.w == r && m_cnt[r] == 1);
    endfunction

    function automatic bit m_stall(vec_t v);
        bit hz;
        hz = (v.s1e && m_hazard(v.s1, v)) || (v.s2e && m_hazard(v.s2, v)) ||
             (v.de && m_cnt[v.d] == MAX_INFLIGHT && !(v.we && v.w == v.d));
        return v.iv && !v.fl && hz;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = 0;
        for (int r = 0; r < N_REGS; r++) if (m_cnt[r] != 0) b[r] = 1'b1;
        return b;
    endfunction

    task automatic m_update(input vec_t v, input bit st);
        bit acc;
        acc = v.iv && !st && !v.fl && v.de;
        if (st && m_scnt < 65535) m_scnt++;
        if (v.fl) begin
            for (int r = 0; r < N_REGS; r++) m_cnt[r] = 0;
        end else if (!(acc && v.we && v.w == v.d)) begin
            if (acc) m_cnt[v.d]++;
            if (v.we) begin
                if (m_cnt[v.w] > 0) m_cnt[v.w]--;
                else                m_uf = 1'b1;
            end
        end
    endtask

    task automatic m_reset();
        for (int r = 0; r < N_REGS; r++) m_cnt[r] = 0;
        m_scnt = 0;
        m_uf   = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        bus.issue_valid = v.iv;
        bus.src1_en     = v.s1e;
        bus.src1_addr   = reg_addr_t'(v.s1);
        bus.src2_en     = v.s2e;
        bus.src2_addr   = reg_addr_t'(v.s2);
        bus.dst_en      = v.de;
        bus.dst_addr    = reg_addr_t'(v.d);
        bus.wb_en       = v.we;
        bus.wb_addr     = reg_addr_t'(v.w);
        bus.flush       = v.fl;
    endtask

    // Called just after a rising edge; samples mid-cycle, returns just after the next edge.
    task automatic step(input vec_t v, input string tag, output bit dut_st);
        bit st;
        drive(v);
        #4;
        st     = m_stall(v);
        dut_st = bus.stall;
        check({tag, " stall"}, bus.stall, st);
        check({tag, " busy"}, bus.busy, m_busy());
        check({tag, " stall_cnt"}, bus.stall_cnt, m_scnt);
        check({tag, " underflow"}, bus.underflow_err, m_uf);
        @(posedge clk);
        m_update(v, st);
        #1;
    endtask

    vec_t tbl [$];
    vec_t v, prev;
    bit   st, last_st;

    initial begin
        m_reset();
        rst = 1'b0;
        drive(mk(1, 1, 3, 1, 3, 1, 3, 0, 0, 0, 0, 0));
        #3;
        check("reset stall", bus.stall, 0);
        check("reset busy", bus.busy, 0);
        check("reset stall_cnt", bus.stall_cnt, 0);
        check("reset underflow", bus.underflow_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        //                iv s1e s1 s2e s2 de d  we w  fl | stall busy_next
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 'h08));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 'h08));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 0, 'h00));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 'h20));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 'h20));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 'h20));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 'h20));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 1, 5, 0, 0, 'h20));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 'h20));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 'h20));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 'h00));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 'h02));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 'h02));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 'h06));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0, 'h00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 'h00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 0, 'h00));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 'h04));
        tbl.push_back(mk(1, 0, 0, 1, 2, 1, 2, 0, 0, 0, 1, 'h04));
        tbl.push_back(mk(1, 1, 2, 0, 0, 1, 2, 1, 2, 0, 0, 'h04));
        tbl.push_back(mk(1, 0, 2, 0, 0, 1, 7, 0, 0, 0, 0, 'h84));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h00));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 'h01));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h01));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h00));

        foreach (tbl[i]) begin
            step(tbl[i], $sformatf("vec%0d", i), st);
            check($sformatf("vec%0d tbl_stall", i), st, tbl[i].exp_stall);
            check($sformatf("vec%0d tbl_busy", i), bus.busy, tbl[i].exp_busy);
        end
        check("tbl sticky underflow", bus.underflow_err, 1);
        check("tbl stall_cnt", bus.stall_cnt, 3);

        last_st = 1'b0;
        prev    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            v = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                   $urandom_range(0, 24) == 0, 0, 0);
            if (last_st) begin
                v.iv = prev.iv; v.s1e = prev.s1e; v.s1 = prev.s1; v.s2e = prev.s2e;
                v.s2 = prev.s2; v.de = prev.de; v.d = prev.d;
            end
            step(v, $sformatf("rnd%0d", n), st);
            last_st = st;
            prev    = v;
        end

        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "sat_flush", st);
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "sat_issue", st);
        v = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(v);
        repeat (70000) @(posedge clk);
        #4;
        check("sat stall", bus.stall, 1);
        check("sat stall_cnt", bus.stall_cnt, 'hFFFF);
        check("sat busy", bus.busy, 'h01);
        check("pre-reset underflow", bus.underflow_err, 1);

        rst = 1'b0;
        #1;
        check("midrst stall", bus.stall, 0);
        check("midrst busy", bus.busy, 0);
        check("midrst stall_cnt", bus.stall_cnt, 0);
        check("midrst underflow", bus.underflow_err, 0);
        m_reset();
        @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check("postrst stall", bus.stall, 0);
        @(posedge clk);
        #1;
        step(v, "postrst_step", st);
        check("postrst busy", bus.busy, 'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
